// File: rtl/icache_line_adaptor.sv
// Line-fill adaptor between the instruction cache and a 64-bit read-burst memory bus.
// Optional next-line prefetch buffer enabled by defining ICACHE_NEXTLINE_PREFETCH_EN.

module icache_line_adaptor #(
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned BEAT_BITS = 64,
   parameter int unsigned COOLDOWN  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [31:0]          line_address,
   input  logic                 line_read,
   output logic [LINE_BITS-1:0] line_rdata,
   output logic                 line_resp,
   output logic [31:0]          burst_address,
   output logic                 burst_read,
   input  logic [BEAT_BITS-1:0] burst_rdata,
   input  logic                 burst_resp
);

   localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
   localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CoolW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
   localparam logic [CoolW-1:0] CoolLast = CoolW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
   typedef enum logic [2:0] {StIdle, StBurst, StResp, StCool, StPf} state_e;
`else
   typedef enum logic [1:0] {StIdle, StBurst, StResp, StCool} state_e;
`endif

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [BeatW-1:0]     beat_cnt_q, beat_cnt_d;
   logic [CoolW-1:0]     cool_cnt_q, cool_cnt_d;
   logic [LINE_BITS-1:0] line_q, line_d;
   logic [31:0]          aligned_addr;
   logic                 last_beat;
   logic                 cool_done;
   logic                 unused_addr_bits;

`ifdef ICACHE_NEXTLINE_PREFETCH_EN
   logic [LINE_BITS-1:0] pf_line_q, pf_line_d;
   logic                 pf_valid_q, pf_valid_d;
`endif

   assign aligned_addr     = {line_address[31:5], 5'b0};
   assign unused_addr_bits = ^line_address[4:0];
   assign last_beat        = (beat_cnt_q == LastBeat);

   function automatic logic [LINE_BITS-1:0] merge_beat(input logic [LINE_BITS-1:0] base,
                                                       input logic [BeatW-1:0]     idx,
                                                       input logic [BEAT_BITS-1:0] beat);
      logic [LINE_BITS-1:0] res;
      res = base;
      // Beat 0 occupies the least-significant slice of the line.
      for (int unsigned i = 0; i < BEATS; i++) begin
         if (idx == BeatW'(i)) begin
            res[i*BEAT_BITS +: BEAT_BITS] = beat;
         end
      end
      return res;
   endfunction

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beat_cnt_d = beat_cnt_q;
      cool_cnt_d = cool_cnt_q;
      line_d     = line_q;
      cool_done  = 1'b0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
      pf_line_d  = pf_line_q;
      pf_valid_d = pf_valid_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (line_read) begin
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
               pf_valid_d = 1'b0;
               // After a prefetch completes, addr_q is the buffer's tag.
               if (pf_valid_q && (aligned_addr == addr_q)) begin
                  line_d  = pf_line_q;
                  state_d = StResp;
               end else begin
                  addr_d     = aligned_addr;
                  beat_cnt_d = '0;
                  state_d    = StBurst;
               end
`else
               addr_d     = aligned_addr;
               beat_cnt_d = '0;
               state_d    = StBurst;
`endif
            end
         end
         StBurst: begin
            if (burst_resp) begin
               line_d     = merge_beat(line_q, beat_cnt_q, burst_rdata);
               beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
               if (last_beat) begin
                  state_d = StResp;
               end
            end
         end
         StResp: begin
            if (COOLDOWN == 0) begin
               cool_done = 1'b1;
            end else begin
               cool_cnt_d = '0;
               state_d    = StCool;
            end
         end
         StCool: begin
            if (cool_cnt_q == CoolLast) begin
               cool_done = 1'b1;
            end else begin
               cool_cnt_d = cool_cnt_q + 1'b1;
            end
         end
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
         StPf: begin
            if (burst_resp) begin
               pf_line_d  = merge_beat(pf_line_q, beat_cnt_q, burst_rdata);
               beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
               if (last_beat) begin
                  pf_valid_d = 1'b1;
                  state_d    = StIdle;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase

      if (cool_done) begin
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
         addr_d     = addr_q + 32'd32;
         beat_cnt_d = '0;
         state_d    = StPf;
`else
         state_d    = StIdle;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         cool_cnt_q <= '0;
         line_q     <= '0;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
         pf_line_q  <= '0;
         pf_valid_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         cool_cnt_q <= cool_cnt_d;
         line_q     <= line_d;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
         pf_line_q  <= pf_line_d;
         pf_valid_q <= pf_valid_d;
`endif
      end
   end

   assign line_resp     = (state_q == StResp);
   assign line_rdata    = line_q;
   assign burst_address = addr_q;
`ifdef ICACHE_NEXTLINE_PREFETCH_EN
   assign burst_read    = (state_q == StBurst) || (state_q == StPf);
`else
   assign burst_read    = (state_q == StBurst);
`endif

endmodule
